// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: serialises one byte per 11-bit frame and backs off when the host inhibits the clock.
// Optional macro PS2_DEV_TX_FIFO_EN replaces the single holding register with a 4-entry FIFO.
module ps2_dev_tx #(
  parameter int unsigned HALF_CYC = 4000,
  parameter int unsigned GAP_CYC  = 8000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned MAX_CYC = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       HALF_LAST = cnt_t'(HALF_CYC - 1);
  localparam cnt_t       GAP_LAST  = cnt_t'(GAP_CYC - 1);
  localparam logic [3:0] LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t     state, state_nx;
  cnt_t       cnt, cnt_nx;
  logic [3:0] bit_cnt, bit_nx;
  logic       dat_q, dat_nx;
  logic       done_q, done_nx;

  logic       clk_meta, clk_sync;
  logic       push;
  logic       have_byte;
  logic [7:0] head;
  logic [10:0] frame;

  // Two-flop synchroniser; idles high so a released bus is assumed out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_i;
      clk_sync <= clk_meta;
    end
  end

  assign push = valid_i && ready_o;

`ifdef PS2_DEV_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fill;

  // The head entry stays put for the whole frame and is popped only on completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= data_i;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (done_q) rd_ptr <= rd_ptr + 2'd1;
      case ({push, done_q})
        2'b10:   fill <= fill + 3'd1;
        2'b01:   fill <= fill - 3'd1;
        default: ;
      endcase
    end
  end

  assign have_byte = (fill != 3'd0);
  assign head      = fifo_mem[rd_ptr];
  assign ready_o   = (fill != 3'd4);
`else
  logic       held;
  logic [7:0] hold_data;

  // Accept needs !held and completion needs held, so the two never coincide.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      held      <= 1'b0;
      hold_data <= '0;
    end else if (done_q) begin
      held      <= 1'b0;
    end else if (push) begin
      held      <= 1'b1;
      hold_data <= data_i;
    end
  end

  assign have_byte = held;
  assign head      = hold_data;
  assign ready_o   = !held;
`endif

  assign frame = {1'b1, ~^head, head, 1'b0};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      dat_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
      dat_q   <= dat_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    dat_nx   = dat_q;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (have_byte && clk_sync) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          bit_nx   = '0;
          dat_nx   = frame[0];
        end
      end
      HIGH: begin
        // Host pulling the clock low while we release it aborts the frame; byte is kept.
        if (!clk_sync) begin
          state_nx = GAP;
          cnt_nx   = '0;
          dat_nx   = 1'b1;
        end else if (cnt == HALF_LAST) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + cnt_t'(1);
        end
      end
      LOW: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nx = GAP;
            dat_nx   = 1'b1;
            done_nx  = 1'b1;
          end else begin
            state_nx = HIGH;
            bit_nx   = bit_cnt + 4'd1;
            dat_nx   = frame[bit_nx];
          end
        end else begin
          cnt_nx = cnt + cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + cnt_t'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ps2_clk_o = (state != LOW);
  assign ps2_dat_o = dat_q;
  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 SHALL have parameter HALF_CYC, default 4000, meaning clk_i cycles per PS/2 clock half-period (12.5 kHz at 100 MHz); legal range 4..65535.
REQ-002 SHALL have parameter GAP_CYC, default 8000, meaning minimum idle clk_i cycles between frames, with both lines released; legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1, the single system clock.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_i, input, 8, the scan-code byte to send.
REQ-006 SHALL have port valid_i, input, 1, which qualifies data_i.
REQ-007 SHALL have port ready_o, output, 1, meaning the block can accept a byte.
REQ-008 SHALL have port ps2_clk_i, input, 1, the asynchronous sampled bus clock used for host-inhibit detection.
REQ-009 SHALL have port ps2_clk_o, output, 1, where 1 = release and 0 = drive low.
REQ-010 SHALL have port ps2_dat_o, output, 1, where 1 = release and 0 = drive low.
REQ-011 SHALL have port busy_o, output, 1, high while a frame or gap is in progress.
REQ-012 SHALL have port done_o, output, 1, a one-cycle pulse per completed frame.

Function
REQ-013 SHALL accept a byte on a clk_i edge where valid_i && ready_o; data_i sampled on that edge.
REQ-014 SHALL send an 11-bit frame: start 0, data[0]..data[7] LSB first, odd parity (XOR of data inverted), stop 1.
REQ-015 SHALL give each bit 2*HALF_CYC cycles: ps2_dat_o updated on entry to the high phase, with ps2_clk_o=1 for HALF_CYC cycles, then ps2_clk_o=0 for HALF_CYC cycles.
REQ-016 SHALL use FSM states IDLE -> HIGH <-> LOW (bit counter 0..10) -> GAP -> IDLE.
REQ-017 SHALL transition IDLE->HIGH on the cycle after a byte is available and the synchronized clock is high; GAP lasts GAP_CYC cycles with both outputs 1.
REQ-018 SHALL take 22*HALF_CYC cycles for a frame, from the first HIGH cycle to the end of the last LOW cycle; done_o pulses in the first GAP cycle.
REQ-019 SHALL synchronize ps2_clk_i through two flops; inhibit = synchronized value is 0 while in HIGH (block releasing clock).
REQ-020 SHALL, on inhibit in HIGH: release both lines, move to GAP, keep the byte, and restart the frame from start bit after GAP expires and the clock is seen high; done_o SHALL NOT pulse.
REQ-021 SHALL ignore ps2_clk_i during LOW (block itself drives low).
REQ-022 SHALL stay in IDLE while the synchronized clock is low, even with a byte pending.
REQ-023 SHALL release the stored byte only at frame completion (entry to GAP without inhibit), never at frame start.
REQ-024 SHALL hold busy_o = (state != IDLE).
REQ-025 SHALL use phase counter width ceil(log2(max(HALF_CYC,GAP_CYC)+1)); counters SHALL never wrap.

Reset
REQ-026 SHALL, on rst_n_i low, immediately and asynchronously set: state IDLE, ps2_clk_o=1, ps2_dat_o=1, ready_o=1, busy_o=0, done_o=0, counters 0, storage empty, synchronizer flops 1.
REQ-027 SHALL abandon a frame in progress on reset mid-frame with no done_o pulse; the pending byte is discarded.
REQ-028 SHALL deassert reset asynchronously and require no extra cycles; the first accept is legal on the first edge after deassertion.

Configuration
REQ-029 SHALL, with macro PS2_DEV_TX_FIFO_EN defined, store bytes in a 4-entry FIFO: ready_o = !full, push and pop in the same cycle permitted, order preserved, and the next frame starts after GAP with no IDLE bubble beyond one cycle.
REQ-030 SHALL, without PS2_DEV_TX_FIFO_EN, use a single holding register: ready_o = !held, so ready_o falls on accept and rises on the cycle after done_o.

Verification
REQ-031 SHALL test HALF_CYC=4, GAP_CYC=8, send 0x1C -> dat per bit 0,0,0,1,1,1,0,0,0,0,1; 11 clock low pulses of 4 cycles each; done_o at cycle 88.
REQ-032 SHALL test send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
REQ-033 SHALL test ps2_clk_i forced low for 20 cycles during the bit-3 HIGH phase -> lines released, no done_o, full frame resent after release plus GAP, done_o once.
REQ-034 SHALL test, with FIFO_EN, 5 back-to-back valid_i for 0x10..0x14 -> 4 accepted and ready_o low on the 5th until the first done_o, then 0x14 accepted; frames emitted in order.
REQ-035 SHALL test, without FIFO_EN, two back-to-back valid_i -> second stalled until the cycle after first done_o.
REQ-036 SHALL test rst_n_i pulsed low mid-LOW phase -> ps2_clk_o=ps2_dat_o=1 the same cycle, ready_o=1, no done_o, next byte sent cleanly.
